regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, issue/decode and register-file signals
interface regfile_wb_arbiter_if;
  logic [2:0]  REQ_VALID;
  logic [14:0] REQ_ADDR;
  logic [95:0] REQ_DATA;
  logic [2:0]  REQ_READY;
  logic        ISS_VALID;
  logic [4:0]  ISS_RD;
  logic [4:0]  RS1_ADDR;
  logic [4:0]  RS2_ADDR;
  logic        HAZARD;
  logic        WB_WRITE;
  logic        WB_HIT;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic [31:0] PENDING;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, ISS_VALID, ISS_RD, RS1_ADDR, RS2_ADDR,
    output REQ_READY, HAZARD, WB_WRITE, WB_HIT, WB_ADDR, WB_DATA, PENDING
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, ISS_VALID, ISS_RD, RS1_ADDR, RS2_ADDR,
    input  REQ_READY, HAZARD, WB_WRITE, WB_HIT, WB_ADDR, WB_DATA, PENDING
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - 3-way writeback arbiter with pending-write scoreboard
// Define REGWB_RR_EN for round-robin arbitration; default is fixed priority 0 > 1 > 2.
module regfile_wb_arbiter (
  input  logic                 CLK,
  input  logic                 RESET,
  regfile_wb_arbiter_if.slave  wb_io
);

  logic [2:0]  grant;
  logic        xfer;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;
  logic        wb_write_q, wb_write_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] pending_q, pending_d;
  logic        hazard;
  logic        iss_set;

`ifdef REGWB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] gnt_idx;

  always_comb begin
    grant = 3'b000;
    if (!RESET) begin
      case (rr_ptr_q)
        2'd1: begin
          if (wb_io.REQ_VALID[1])      grant = 3'b010;
          else if (wb_io.REQ_VALID[2]) grant = 3'b100;
          else if (wb_io.REQ_VALID[0]) grant = 3'b001;
        end
        2'd2: begin
          if (wb_io.REQ_VALID[2])      grant = 3'b100;
          else if (wb_io.REQ_VALID[0]) grant = 3'b001;
          else if (wb_io.REQ_VALID[1]) grant = 3'b010;
        end
        default: begin
          if (wb_io.REQ_VALID[0])      grant = 3'b001;
          else if (wb_io.REQ_VALID[1]) grant = 3'b010;
          else if (wb_io.REQ_VALID[2]) grant = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    gnt_idx = 2'd0;
    if (grant[1]) gnt_idx = 2'd1;
    if (grant[2]) gnt_idx = 2'd2;
    rr_ptr_d = rr_ptr_q;
    // Search restarts just past the winner, so only a real transfer moves it.
    if (xfer) rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) rr_ptr_q <= 2'd0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    grant = 3'b000;
    if (!RESET) begin
      if (wb_io.REQ_VALID[0])      grant = 3'b001;
      else if (wb_io.REQ_VALID[1]) grant = 3'b010;
      else if (wb_io.REQ_VALID[2]) grant = 3'b100;
    end
  end
`endif

  assign xfer = |grant;

  always_comb begin
    gnt_addr = wb_io.REQ_ADDR[4:0];
    gnt_data = wb_io.REQ_DATA[31:0];
    if (grant[1]) begin
      gnt_addr = wb_io.REQ_ADDR[9:5];
      gnt_data = wb_io.REQ_DATA[63:32];
    end
    if (grant[2]) begin
      gnt_addr = wb_io.REQ_ADDR[14:10];
      gnt_data = wb_io.REQ_DATA[95:64];
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_comb begin
    wb_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (xfer) begin
      wb_write_d = (gnt_addr != 5'd0);
      wb_addr_d  = gnt_addr;
      wb_data_d  = gnt_data;
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (!RESET) begin
      hazard = ((wb_io.RS1_ADDR != 5'd0) && pending_q[wb_io.RS1_ADDR]) ||
               ((wb_io.RS2_ADDR != 5'd0) && pending_q[wb_io.RS2_ADDR]) ||
               (wb_io.ISS_VALID && (wb_io.ISS_RD != 5'd0) && pending_q[wb_io.ISS_RD]);
    end
  end

  assign iss_set = wb_io.ISS_VALID && (wb_io.ISS_RD != 5'd0) && !hazard;

  // Clear first, then set, so an issue landing on the commit edge keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (wb_write_q) pending_d[wb_addr_q] = 1'b0;
    if (iss_set)    pending_d[wb_io.ISS_RD] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wb_write_q <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      pending_q  <= 32'd0;
    end else begin
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      pending_q  <= pending_d;
    end
  end

  assign wb_io.REQ_READY = grant;
  assign wb_io.HAZARD    = hazard;
  assign wb_io.WB_WRITE  = wb_write_q;
  assign wb_io.WB_HIT    = wb_write_q;
  assign wb_io.WB_ADDR   = wb_addr_q;
  assign wb_io.WB_DATA   = wb_data_q;
  assign wb_io.PENDING   = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - vector table, directed sequences and random run against a reference model
module tb_regfile_wb_arbiter;

  logic CLK = 1'b0;
  logic RESET;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .wb_io (bus)
  );

  always #5 CLK = ~CLK;

`ifdef REGWB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pend;
  logic        m_wb;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_ptr;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d;
    logic        iv;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  e_ready;
    logic        e_haz;
    logic        e_wb;
  } vec_t;

  vec_t vecs [10];
  logic [2:0] exp31 [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  task automatic idle();
    RESET         = 1'b0;
    bus.REQ_VALID = 3'b000;
    bus.REQ_ADDR  = 15'd0;
    bus.REQ_DATA  = 96'd0;
    bus.ISS_VALID = 1'b0;
    bus.ISS_RD    = 5'd0;
    bus.RS1_ADDR  = 5'd0;
    bus.RS2_ADDR  = 5'd0;
  endtask

  // Compare everything against the model, advance the model one edge, end at next negedge.
  task automatic cyc();
    int          g;
    logic [31:0] e_ready;
    logic        e_haz;
    logic [4:0]  a;
    logic [31:0] n_pend;
    logic        n_wb;
    logic [4:0]  n_addr;
    logic [31:0] n_data;
    #1;
    g = RESET ? -1 : pick(bus.REQ_VALID);
    e_ready = (g < 0) ? 32'd0 : (32'd1 << g);
    e_haz = !RESET && (((bus.RS1_ADDR != 0) && m_pend[bus.RS1_ADDR]) ||
                       ((bus.RS2_ADDR != 0) && m_pend[bus.RS2_ADDR]) ||
                       (bus.ISS_VALID && (bus.ISS_RD != 0) && m_pend[bus.ISS_RD]));
    check("req_ready", {29'd0, bus.REQ_READY}, e_ready);
    check("hazard",    {31'd0, bus.HAZARD},    {31'd0, e_haz});
    check("wb_write",  {31'd0, bus.WB_WRITE},  {31'd0, m_wb});
    check("wb_hit",    {31'd0, bus.WB_HIT},    {31'd0, m_wb});
    check("wb_addr",   {27'd0, bus.WB_ADDR},   {27'd0, m_addr});
    check("wb_data",   bus.WB_DATA,            m_data);
    check("pending",   bus.PENDING,            m_pend);
    if (RESET) begin
      n_pend = 32'd0; n_wb = 1'b0; n_addr = 5'd0; n_data = 32'd0; m_ptr = 0;
    end else begin
      n_pend = m_pend;
      if (m_wb) n_pend[m_addr] = 1'b0;
      if (bus.ISS_VALID && bus.ISS_RD != 0 && !e_haz) n_pend[bus.ISS_RD] = 1'b1;
      n_wb = 1'b0; n_addr = m_addr; n_data = m_data;
      if (g >= 0) begin
        a = bus.REQ_ADDR[5*g +: 5];
        n_wb = (a != 5'd0);
        n_addr = a;
        n_data = bus.REQ_DATA[32*g +: 32];
        m_ptr = RR ? (g + 1) % 3 : 0;
      end
    end
    @(posedge CLK);
    m_pend = n_pend; m_wb = n_wb; m_addr = n_addr; m_data = n_data;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
  endtask

  initial begin
    idle();
    RESET = 1'b1;
    m_pend = 0; m_wb = 0; m_addr = 0; m_data = 0; m_ptr = 0;
    @(posedge CLK);
    @(negedge CLK);

    vecs[0] = '{1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'b010, 5'd0, 5'd3, 5'd0, 32'h33, 1'b0, 5'd0, 5'd3, 5'd0, 3'b010, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd0, 3'b000, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'h44, 1'b0, 5'd0, 5'd3, 5'd0, 3'b001, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd4, 32'h55, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 3'b011, 5'd6, 5'd8, 5'd0, 32'h66, 1'b0, 5'd0, 5'd0, 5'd3, 3'b001, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 3'b010, 5'd0, 5'd8, 5'd0, 32'h77, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      RESET         = vecs[i].rst;
      bus.REQ_VALID = vecs[i].v;
      bus.REQ_ADDR  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      bus.REQ_DATA  = {vecs[i].d + 32'd2, vecs[i].d + 32'd1, vecs[i].d};
      bus.ISS_VALID = vecs[i].iv;
      bus.ISS_RD    = vecs[i].rd;
      bus.RS1_ADDR  = vecs[i].rs1;
      bus.RS2_ADDR  = vecs[i].rs2;
      #1;
      check($sformatf("vec%0d_ready", i), {29'd0, bus.REQ_READY}, {29'd0, vecs[i].e_ready});
      check($sformatf("vec%0d_hazard", i), {31'd0, bus.HAZARD}, {31'd0, vecs[i].e_haz});
      check($sformatf("vec%0d_wb", i), {31'd0, bus.WB_WRITE}, {31'd0, vecs[i].e_wb});
      cyc();
    end

    // Issue rd=5, then requester 1 writes x5
    do_reset();
    idle(); bus.ISS_VALID = 1'b1; bus.ISS_RD = 5'd5; cyc();
    check("s30_pend5", bus.PENDING, 32'h0000_0020);
    idle(); bus.RS1_ADDR = 5'd5; bus.REQ_VALID = 3'b010;
    bus.REQ_ADDR = {5'd0, 5'd5, 5'd0}; bus.REQ_DATA = {32'd0, 32'hDEAD_0001, 32'd0};
    #1;
    check("s30_haz_a", {31'd0, bus.HAZARD}, 32'd1);
    check("s30_ready", {29'd0, bus.REQ_READY}, 32'd2);
    cyc();
    check("s30_wb", {31'd0, bus.WB_WRITE}, 32'd1);
    check("s30_addr", {27'd0, bus.WB_ADDR}, 32'd5);
    check("s30_data", bus.WB_DATA, 32'hDEAD_0001);
    idle(); bus.RS1_ADDR = 5'd5; #1;
    check("s30_haz_b", {31'd0, bus.HAZARD}, 32'd1);
    cyc();
    #1;
    check("s30_haz_c", {31'd0, bus.HAZARD}, 32'd0);
    check("s30_pend_clr", bus.PENDING, 32'd0);
    cyc();

    // All three requesters valid for three cycles
    do_reset();
    if (RR) begin
      exp31[0] = 3'b001; exp31[1] = 3'b010; exp31[2] = 3'b100;
    end else begin
      exp31[0] = 3'b001; exp31[1] = 3'b001; exp31[2] = 3'b001;
    end
    for (int c = 0; c < 3; c++) begin
      idle(); bus.REQ_VALID = 3'b111;
      bus.REQ_ADDR = {5'd12, 5'd11, 5'd10};
      bus.REQ_DATA = {32'hC2, 32'hC1, 32'hC0};
      #1;
      check($sformatf("s31_grant%0d", c), {29'd0, bus.REQ_READY}, {29'd0, exp31[c]});
      cyc();
    end

    // Write to x0 is accepted but discarded
    do_reset();
    idle(); bus.REQ_VALID = 3'b001; bus.REQ_ADDR = 15'd0; bus.REQ_DATA = {64'd0, 32'h1234};
    #1;
    check("s32_ready", {29'd0, bus.REQ_READY}, 32'd1);
    cyc();
    check("s32_wb", {31'd0, bus.WB_WRITE}, 32'd0);
    check("s32_hit", {31'd0, bus.WB_HIT}, 32'd0);
    check("s32_pend", bus.PENDING, 32'd0);

    // Issue of rd=7 on the edge that commits x7: set wins
    do_reset();
    idle(); bus.REQ_VALID = 3'b001; bus.REQ_ADDR = {10'd0, 5'd7}; bus.REQ_DATA = {64'd0, 32'h7777};
    cyc();
    check("s33_wb", {31'd0, bus.WB_WRITE}, 32'd1);
    idle(); bus.ISS_VALID = 1'b1; bus.ISS_RD = 5'd7; #1;
    check("s33_haz0", {31'd0, bus.HAZARD}, 32'd0);
    cyc();
    check("s33_pend7", bus.PENDING, 32'h0000_0080);
    idle(); bus.ISS_VALID = 1'b1; bus.ISS_RD = 5'd7; #1;
    check("s33_haz1", {31'd0, bus.HAZARD}, 32'd1);
    cyc();
    check("s33_pend7b", bus.PENDING, 32'h0000_0080);

    // Reset right after a transfer to x9 drops the write
    do_reset();
    idle(); bus.ISS_VALID = 1'b1; bus.ISS_RD = 5'd9; cyc();
    idle(); bus.RS1_ADDR = 5'd9; bus.REQ_VALID = 3'b100;
    bus.REQ_ADDR = {5'd9, 10'd0}; bus.REQ_DATA = {32'h9999, 64'd0};
    #1;
    check("s34_ready_a", {29'd0, bus.REQ_READY}, 32'd4);
    cyc();
    RESET = 1'b1; bus.REQ_VALID = 3'b111; #1;
    check("s34_ready_rst", {29'd0, bus.REQ_READY}, 32'd0);
    check("s34_haz_rst", {31'd0, bus.HAZARD}, 32'd0);
    cyc();
    check("s34_wb_rst", {31'd0, bus.WB_WRITE}, 32'd0);
    check("s34_pend_rst", bus.PENDING, 32'd0);
    idle(); bus.REQ_VALID = 3'b100; bus.REQ_ADDR = {5'd9, 10'd0}; bus.REQ_DATA = {32'h9A9A, 64'd0};
    cyc();
    check("s34_wb", {31'd0, bus.WB_WRITE}, 32'd1);
    check("s34_addr", {27'd0, bus.WB_ADDR}, 32'd9);
    check("s34_data", bus.WB_DATA, 32'h9A9A);

    // Random traffic with small register range to provoke hazards and collisions
    for (int n = 0; n < 1500; n++) begin
      RESET         = ($urandom_range(0, 49) == 0);
      bus.REQ_VALID = 3'($urandom_range(0, 7));
      bus.REQ_ADDR  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.REQ_DATA  = {$urandom, $urandom, $urandom};
      bus.ISS_VALID = 1'($urandom_range(0, 1));
      bus.ISS_RD    = 5'($urandom_range(0, 7));
      bus.RS1_ADDR  = 5'($urandom_range(0, 7));
      bus.RS2_ADDR  = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
